// File: rtl/fault_recovery_ctrl.sv
// Supervisory sequencer for the power stage: detector reset, soft-start, derating,
// fault cooldown/retry and lockout after repeated consecutive failures.
module fault_recovery_ctrl #(
  parameter int RST_CYCLES       = 4,
  parameter int RAMP_STEP        = 32,
  parameter int RAMP_STEP_CYCLES = 8,
  parameter int DUTY_MAX         = 255,
  parameter int COOLDOWN_CYCLES  = 64,
  parameter int MAX_RETRIES      = 3,
  parameter int STABLE_CYCLES    = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clear_lockout,
  input  logic       det_warning,
  input  logic       det_fault,
  input  logic       det_shutdown,
  output logic       det_rstn,
  output logic       pwr_en,
  output logic [7:0] duty,
  output logic [2:0] retry_cnt,
  output logic       lockout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DET_RESET = 3'd1,
    SOFTSTART = 3'd2,
    RUN       = 3'd3,
    COOLDOWN  = 3'd4,
    LOCKOUT   = 3'd5
  } state_t;

  localparam int CNT_TOP = (RST_CYCLES > RAMP_STEP_CYCLES) ?
                           ((RST_CYCLES > COOLDOWN_CYCLES) ? RST_CYCLES : COOLDOWN_CYCLES) :
                           ((RAMP_STEP_CYCLES > COOLDOWN_CYCLES) ? RAMP_STEP_CYCLES : COOLDOWN_CYCLES);
  localparam int CNT_W   = $clog2(CNT_TOP + 1);
  localparam int STB_W   = $clog2(STABLE_CYCLES + 1);

  state_t           state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [STB_W-1:0] stable_q, stable_nx;
  logic [7:0]       duty_nx;
  logic [2:0]       retry_nx;
  logic [8:0]       ramp_sum;
  logic             fail;
  logic             active_nx;

  assign state = state_q;
  assign fail  = det_fault | det_shutdown;

  // NOTE: every signal written below gets a default first, so no path can leave it unassigned (no latches).
  always_comb begin
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    stable_nx = '0;
    duty_nx   = duty;
    retry_nx  = retry_cnt;
    ramp_sum  = {1'b0, duty} + 9'(RAMP_STEP);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_nx = DET_RESET;
          cnt_nx   = '0;
        end
      end
      DET_RESET: begin
        if (!start) begin
          state_nx = IDLE;
        end else if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_nx = SOFTSTART;
          cnt_nx   = '0;
          duty_nx  = '0;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
      SOFTSTART, RUN: begin
        if (fail) begin
          state_nx = COOLDOWN;
          cnt_nx   = '0;
          retry_nx = (retry_cnt == 3'd7) ? 3'd7 : retry_cnt + 3'd1;
        end else if (!start) begin
          state_nx = IDLE;
        end else if (state_q == RUN || duty == 8'(DUTY_MAX)) begin
          state_nx = RUN;
          duty_nx  = det_warning ? 8'(DUTY_MAX >> 1) : 8'(DUTY_MAX);
          if (state_q == RUN) begin
            stable_nx = (stable_q == STB_W'(STABLE_CYCLES)) ? stable_q : stable_q + 1'b1;
            if (stable_nx == STB_W'(STABLE_CYCLES)) retry_nx = '0;
          end
        end else if (!det_warning) begin
          if (cnt_q == CNT_W'(RAMP_STEP_CYCLES - 1)) begin
            cnt_nx  = '0;
            // Sum is 9 bits wide so a step past full scale clamps instead of wrapping.
            duty_nx = (ramp_sum > 9'(DUTY_MAX)) ? 8'(DUTY_MAX) : ramp_sum[7:0];
          end else begin
            cnt_nx = cnt_q + 1'b1;
          end
        end
      end
      COOLDOWN: begin
        // Lockout takes precedence over a dropped start so an exhausted retry budget always latches.
        if (retry_cnt > 3'(MAX_RETRIES)) begin
          state_nx = LOCKOUT;
        end else if (!start) begin
          state_nx = IDLE;
        end else if (cnt_q == CNT_W'(COOLDOWN_CYCLES - 1)) begin
          state_nx = DET_RESET;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
      LOCKOUT: begin
        if (clear_lockout) begin
          state_nx = IDLE;
          retry_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase

    active_nx = (state_nx == SOFTSTART) || (state_nx == RUN);
    if (!active_nx) duty_nx = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      stable_q  <= '0;
      duty      <= '0;
      retry_cnt <= '0;
      det_rstn  <= 1'b0;
      pwr_en    <= 1'b0;
      lockout   <= 1'b0;
    end else begin
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      stable_q  <= stable_nx;
      duty      <= duty_nx;
      retry_cnt <= retry_nx;
      det_rstn  <= active_nx;
      pwr_en    <= active_nx;
      lockout   <= (state_nx == LOCKOUT);
    end
  end

endmodule

// File: tb/tb_fault_recovery_ctrl.sv
// Scoreboard bench for fault_recovery_ctrl: a phase/elapsed-time reference model queues
// the expected outputs for each edge, and a monitor compares them against the DUT.
module tb_fault_recovery_ctrl;

  localparam int RST_CYCLES       = 4;
  localparam int RAMP_STEP        = 32;
  localparam int RAMP_STEP_CYCLES = 8;
  localparam int DUTY_MAX         = 255;
  localparam int COOLDOWN_CYCLES  = 64;
  localparam int MAX_RETRIES      = 3;
  localparam int STABLE_CYCLES    = 256;

  localparam int S_IDLE = 0, S_DR = 1, S_SS = 2, S_RUN = 3, S_CD = 4, S_LO = 5;

  logic       clk = 1'b0;
  logic       rst, start, clear_lockout, det_warning, det_fault, det_shutdown;
  logic       det_rstn, pwr_en, lockout;
  logic [7:0] duty;
  logic [2:0] retry_cnt, state;

  fault_recovery_ctrl #(
    .RST_CYCLES(RST_CYCLES), .RAMP_STEP(RAMP_STEP), .RAMP_STEP_CYCLES(RAMP_STEP_CYCLES),
    .DUTY_MAX(DUTY_MAX), .COOLDOWN_CYCLES(COOLDOWN_CYCLES), .MAX_RETRIES(MAX_RETRIES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear_lockout(clear_lockout),
    .det_warning(det_warning), .det_fault(det_fault), .det_shutdown(det_shutdown),
    .det_rstn(det_rstn), .pwr_en(pwr_en), .duty(duty), .retry_cnt(retry_cnt),
    .lockout(lockout), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int duty;
    int retry;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: phase plus elapsed-cycle bookkeeping; duty in soft-start is derived
  // from the number of non-warning cycles spent ramping.
  int m_state, m_duty, m_retry, m_phase, m_active, m_stable;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void enter(input int s);
    m_state  = s;
    m_phase  = 0;
    m_active = 0;
    m_stable = 0;
  endfunction

  function automatic void model_step(input bit r, s, c, w, f, sh);
    if (r) begin
      enter(S_IDLE);
      m_retry = 0;
      m_duty  = 0;
      return;
    end
    case (m_state)
      S_IDLE: if (s) enter(S_DR);
      S_DR: begin
        if (!s) enter(S_IDLE);
        else begin
          m_phase++;
          if (m_phase == RST_CYCLES) enter(S_SS);
        end
      end
      S_SS, S_RUN: begin
        if (f || sh) begin
          m_retry = (m_retry < 7) ? m_retry + 1 : 7;
          enter(S_CD);
        end else if (!s) enter(S_IDLE);
        else if (m_state == S_RUN) begin
          if (m_stable < STABLE_CYCLES) m_stable++;
          if (m_stable == STABLE_CYCLES) m_retry = 0;
        end else if (m_duty == DUTY_MAX) enter(S_RUN);
        else if (!w) begin
          m_active++;
          m_duty = RAMP_STEP * (m_active / RAMP_STEP_CYCLES);
          if (m_duty > DUTY_MAX) m_duty = DUTY_MAX;
        end
      end
      S_CD: begin
        if (m_retry > MAX_RETRIES) enter(S_LO);
        else if (!s) enter(S_IDLE);
        else begin
          m_phase++;
          if (m_phase == COOLDOWN_CYCLES) enter(S_DR);
        end
      end
      S_LO: if (c) begin
        enter(S_IDLE);
        m_retry = 0;
      end
      default: enter(S_IDLE);
    endcase
    if (m_state == S_RUN) m_duty = w ? DUTY_MAX / 2 : DUTY_MAX;
    else if (m_state != S_SS) m_duty = 0;
  endfunction

  task automatic cyc(input bit r, s, c, w, f, sh);
    exp_t e;
    @(negedge clk);
    rst = r; start = s; clear_lockout = c; det_warning = w; det_fault = f; det_shutdown = sh;
    model_step(r, s, c, w, f, sh);
    e.st = m_state; e.duty = m_duty; e.retry = m_retry;
    exp_q.push_back(e);
  endtask

  task automatic nominal();
    cyc(0, 1, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: budget expired (model state %0d)", name, m_state);
  endtask

  task automatic run_until_state(input int target, input int budget);
    int n = 0;
    while (m_state != target && n < budget) begin
      nominal();
      n++;
    end
    if (m_state != target) timeout("reach_state");
  endtask

  task automatic run_until_duty(input int target, input int budget);
    int n = 0;
    while (m_duty != target && n < budget) begin
      nominal();
      n++;
    end
    if (m_duty != target) timeout("reach_duty");
  endtask

  task automatic build_retry2();
    cyc(1, 0, 0, 0, 0, 0);
    repeat (2) begin
      run_until_state(S_SS, 200);
      cyc(0, 1, 0, 0, 1, 0);
    end
    run_until_state(S_RUN, 400);
  endtask

  // Monitor: every edge presents a full output set; compare against the queued expectation.
  initial begin
    exp_t e;
    bit act_on;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        act_on = (e.st == S_SS) || (e.st == S_RUN);
        check("state", 32'(state), 32'(e.st));
        check("duty", 32'(duty), 32'(e.duty));
        check("retry_cnt", 32'(retry_cnt), 32'(e.retry));
        check("pwr_en", 32'(pwr_en), 32'(act_on));
        check("det_rstn", 32'(det_rstn), 32'(act_on));
        check("lockout", 32'(lockout), 32'(e.st == S_LO));
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; clear_lockout = 1'b0;
    det_warning = 1'b0; det_fault = 1'b0; det_shutdown = 1'b0;
    m_state = S_IDLE; m_duty = 0; m_retry = 0; m_phase = 0; m_active = 0; m_stable = 0;

    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    settle();
    check("reset_state", 32'(state), 0);
    check("reset_det_rstn", 32'(det_rstn), 0);

    // Nominal ramp to RUN
    nominal();
    run_until_state(S_RUN, 200);
    settle();
    check("run_duty", 32'(duty), 255);
    check("run_pwr_en", 32'(pwr_en), 1);

    // Warning derate in RUN
    repeat (10) cyc(0, 1, 0, 1, 0, 0);
    settle();
    check("run_derate", 32'(duty), 127);
    repeat (5) nominal();

    // Warning freezes the soft-start ramp
    cyc(0, 0, 0, 0, 0, 0);
    nominal();
    run_until_duty(96, 200);
    repeat (12) cyc(0, 1, 0, 1, 0, 0);
    settle();
    check("ss_freeze", 32'(duty), 96);
    run_until_state(S_RUN, 200);

    // Single fault in RUN, cooldown and retry
    cyc(0, 1, 0, 0, 1, 0);
    settle();
    check("fault_state", 32'(state), S_CD);
    check("fault_retry", 32'(retry_cnt), 1);
    run_until_state(S_RUN, 300);

    // Four consecutive shutdowns in SOFTSTART lock out
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      run_until_state(S_SS, 200);
      cyc(0, 1, 0, 0, 0, 1);
    end
    nominal();
    settle();
    check("lockout_state", 32'(state), S_LO);
    check("lockout_retry", 32'(retry_cnt), 4);
    for (int i = 0; i < 10; i++) cyc(0, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    settle();
    check("clear_state", 32'(state), S_IDLE);
    check("clear_retry", 32'(retry_cnt), 0);

    // Stable RUN clears retry_cnt at exactly STABLE_CYCLES
    build_retry2();
    repeat (STABLE_CYCLES - 1) nominal();
    settle();
    check("stable_pre", 32'(retry_cnt), 2);
    nominal();
    settle();
    check("stable_clear", 32'(retry_cnt), 0);

    // Fault on the last cycle before the stable clear
    build_retry2();
    repeat (STABLE_CYCLES - 2) nominal();
    cyc(0, 1, 0, 0, 1, 0);
    settle();
    check("stable_fault_retry", 32'(retry_cnt), 3);

    // Fault coincident with start=0 takes the failure path
    cyc(1, 0, 0, 0, 0, 0);
    nominal();
    run_until_state(S_RUN, 200);
    cyc(0, 0, 0, 0, 1, 0);
    settle();
    check("fault_vs_stop", 32'(state), S_CD);

    // start=0 mid soft-start, then rst mid RUN
    cyc(0, 0, 0, 0, 0, 0);
    nominal();
    run_until_duty(64, 200);
    cyc(0, 0, 0, 0, 0, 0);
    settle();
    check("abort_ss_state", 32'(state), S_IDLE);
    check("abort_ss_duty", 32'(duty), 0);
    nominal();
    run_until_state(S_RUN, 200);
    cyc(1, 1, 0, 0, 0, 0);
    settle();
    check("rst_run_pwr_en", 32'(pwr_en), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 19) != 0),
          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 149) == 0));
    end

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) timeout("scoreboard_drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
